param_mdc: RTL and testbench

Parametrised greatest-common-divisor (MDC) engine; successor to the fixed 8-bit behavioural MDC block. Computes gcd(x, y) for WIDTH-bit unsigned operands using the binary (Stein) algorithm. Uses valid/ready handshakes on input and output, a clock-enable freeze, and a coprime flag. Sits between an operand producer and a result consumer in the arithmetic challenge datapath.

---
 rtl/mdc_pkg.sv | 11 +
 rtl/param_mdc.sv | 105 ++++++++++
 tb/tb_param_mdc.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mdc_pkg.sv
// rtl/mdc_pkg.sv - shared state type and latency bound for the binary gcd engine
package mdc_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, REDUCE, DONE} mdc_state_t;

  // Worst-case enabled edges from accept to result for a given operand width
  function automatic int mdc_latency_max(input int width);
    return 3 * width + 2;
  endfunction

endpackage

// File: rtl/param_mdc.sv
// rtl/param_mdc.sv - parametrised binary (Stein) gcd engine with valid/ready handshakes
module param_mdc
  import mdc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enb_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] dtx_i,
  input  logic [WIDTH-1:0] dty_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] dt_o,
  output logic             coprime_o,
  output logic             busy_o
);

  localparam int KW = $clog2(WIDTH);

  mdc_state_t       state, state_n;
  logic [WIDTH-1:0] a, a_n;
  logic [WIDTH-1:0] b, b_n;
  logic [WIDTH-1:0] dt, dt_n;
  logic [KW-1:0]    k, k_n;

  // Handshake and status outputs come only from registered state and enb_i
  assign in_ready_o  = enb_i && (state == IDLE);
  assign out_valid_o = enb_i && (state == DONE);
  assign busy_o      = (state == SHIFT) || (state == REDUCE);
  // Qualified by DONE rather than out_valid_o so the flag holds through a freeze
  assign coprime_o   = (state == DONE) && (dt == WIDTH'(1));
  assign dt_o        = dt;

  // Next-state and datapath next values; k counts shared factors of two
  always_comb begin
    state_n = state;
    a_n     = a;
    b_n     = b;
    k_n     = k;
    dt_n    = dt;
    case (state)
      IDLE: begin
        if (in_valid_i) begin
          a_n     = dtx_i;
          b_n     = dty_i;
          k_n     = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if ((a == '0) || (b == '0)) begin
          dt_n    = a | b;
          state_n = DONE;
        end else if (!a[0] && !b[0]) begin
          a_n = a >> 1;
          b_n = b >> 1;
          k_n = k + 1'b1;
        end else begin
          state_n = REDUCE;
        end
      end
      REDUCE: begin
        if (!a[0]) begin
          a_n = a >> 1;
        end else if (!b[0]) begin
          b_n = b >> 1;
        end else if (a == b) begin
          dt_n    = a << k;
          state_n = DONE;
        end else if (a > b) begin
          a_n = (a - b) >> 1;
        end else begin
          b_n = (b - a) >> 1;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers; nothing moves while enb_i is low
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      k     <= '0;
      dt    <= '0;
    end else if (enb_i) begin
      state <= state_n;
      a     <= a_n;
      b     <= b_n;
      k     <= k_n;
      dt    <= dt_n;
    end
  end

endmodule

// File: tb/tb_param_mdc.sv
// tb/tb_param_mdc.sv - self-checking bench for param_mdc
module tb_param_mdc;
  import mdc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enb = 1'b1;

  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0]  dtx = '0, dty = '0;
  logic        in_ready, out_valid, coprime, busy;
  logic [7:0]  dt;

  logic        in_valid16 = 1'b0, out_ready16 = 1'b0;
  logic [15:0] dtx16 = '0, dty16 = '0;
  logic        in_ready16, out_valid16, coprime16, busy16;
  logic [15:0] dt16;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  param_mdc #(.WIDTH(8)) u8 (
    .clk_i(clk), .rst_i(rst), .enb_i(enb),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .dtx_i(dtx), .dty_i(dty),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .dt_o(dt), .coprime_o(coprime), .busy_o(busy)
  );

  param_mdc #(.WIDTH(16)) u16 (
    .clk_i(clk), .rst_i(rst), .enb_i(enb),
    .in_valid_i(in_valid16), .in_ready_o(in_ready16),
    .dtx_i(dtx16), .dty_i(dty16),
    .out_valid_o(out_valid16), .out_ready_i(out_ready16),
    .dt_o(dt16), .coprime_o(coprime16), .busy_o(busy16)
  );

  // Subtractive Euclid golden model
  function automatic int unsigned gold_gcd(input int unsigned x, input int unsigned y);
    while (x != 0 && y != 0) begin
      if (x > y) x = x - y;
      else       y = y - x;
    end
    return x | y;
  endfunction

  // Present one operand pair, scramble inputs after accept, wait for the result.
  // lat counts edges starting at the accept edge; -1 signals a timeout.
  task automatic run8(input logic [7:0] x, input logic [7:0] y,
                      output logic [7:0] res, output logic cp, output int lat);
    @(negedge clk);
    dtx = x; dty = y; in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    #1;
    in_valid = 1'b0;
    dtx = 8'($urandom); dty = 8'($urandom);
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid) lat = -1;
    res = dt;
    cp  = coprime;
  endtask

  task automatic ack8();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp += 6;
    if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    if (dt !== 8'd0)        begin n_fail++; $display("FAIL reset_dt got %0d want 0", dt); end
    if (coprime !== 1'b0)   begin n_fail++; $display("FAIL reset_coprime got %b want 0", coprime); end
    if (dt16 !== 16'd0)     begin n_fail++; $display("FAIL reset_dt16 got %0d want 0", dt16); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] r; logic cp; int lat;
    run8(8'd12, 8'd18, r, cp, lat);
    n_cmp += 3;
    if (r !== 8'd6)   begin n_fail++; $display("FAIL basic_dt got %0d want 6", r); end
    if (cp !== 1'b0)  begin n_fail++; $display("FAIL basic_coprime got %b want 0", cp); end
    if (lat != 6)     begin n_fail++; $display("FAIL basic_latency got %0d want 6", lat); end
    ack8();
  endtask

  task automatic test_zero();
    logic [7:0] r; logic cp; int lat;
    logic [7:0] xs [3] = '{8'd0, 8'd37, 8'd0};
    logic [7:0] ys [3] = '{8'd0, 8'd0, 8'd200};
    for (int i = 0; i < 3; i++) begin
      run8(xs[i], ys[i], r, cp, lat);
      n_cmp += 2;
      if (r !== 8'(gold_gcd(xs[i], ys[i]))) begin
        n_fail++; $display("FAIL zero_dt[%0d] got %0d want %0d", i, r, gold_gcd(xs[i], ys[i]));
      end
      if (lat != 2) begin n_fail++; $display("FAIL zero_latency[%0d] got %0d want 2", i, lat); end
      ack8();
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] r; logic cp; int lat;
    run8(8'd1, 8'd255, r, cp, lat);
    n_cmp += 3;
    if (r !== 8'd1)  begin n_fail++; $display("FAIL bp_dt got %0d want 1", r); end
    if (cp !== 1'b1) begin n_fail++; $display("FAIL bp_coprime got %b want 1", cp); end
    if (lat != 10)   begin n_fail++; $display("FAIL bp_latency got %0d want 10", lat); end
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || dt !== 8'd1 || in_ready !== 1'b0 || coprime !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got valid=%b dt=%0d ready=%b cp=%b want 1/1/0/1",
                 i, out_valid, dt, in_ready, coprime);
      end
    end
    in_valid = 1'b0;
    ack8();
  endtask

  task automatic test_width16();
    int lat = 1;
    @(negedge clk);
    dtx16 = 16'h8000; dty16 = 16'h4000; in_valid16 = 1'b1;
    @(posedge clk);
    #1 in_valid16 = 1'b0; dtx16 = 16'h1234; dty16 = 16'h0777;
    @(negedge clk);
    while (!out_valid16 && lat < 300) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    n_cmp += 2;
    if (dt16 !== 16'h4000) begin n_fail++; $display("FAIL w16_dt got %h want 4000", dt16); end
    if (lat != 18)         begin n_fail++; $display("FAIL w16_latency got %0d want 18", lat); end
    out_ready16 = 1'b1;
    @(posedge clk);
    #1 out_ready16 = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] r; logic cp; int lat; logic [7:0] x, y; int unsigned g;
    int bound = mdc_latency_max(8);
    logic [7:0] cx [6] = '{8'd255, 8'd128, 8'd255, 8'd1, 8'd254, 8'd96};
    logic [7:0] cy [6] = '{8'd255, 8'd128, 8'd1, 8'd1, 8'd127, 8'd160};
    for (int i = 0; i < 1006; i++) begin
      if (i < 6) begin
        x = cx[i]; y = cy[i];
      end else begin
        x = 8'($urandom); y = 8'($urandom);
        if (i % 3 == 0) begin
          x = x & 8'hF0; y = y & 8'hF8;
        end
      end
      g = gold_gcd(x, y);
      run8(x, y, r, cp, lat);
      n_cmp += 3;
      if (r !== 8'(g)) begin n_fail++; $display("FAIL rnd_dt x=%0d y=%0d got %0d want %0d", x, y, r, g); end
      if (cp !== (g == 1)) begin n_fail++; $display("FAIL rnd_coprime x=%0d y=%0d got %b want %b", x, y, cp, g == 1); end
      if (lat < 2 || lat > bound) begin
        n_fail++; $display("FAIL rnd_latency x=%0d y=%0d got %0d want 2..%0d", x, y, lat, bound);
      end
      ack8();
    end
  endtask

  task automatic test_enable_freeze();
    int lat = 1;
    @(negedge clk);
    dtx = 8'd1; dty = 8'd255; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) begin @(posedge clk); lat++; end
    @(negedge clk);
    enb = 1'b0; dtx = 8'd12; dty = 8'd18; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL freeze_outputs[%0d] got valid=%b ready=%b busy=%b want 0/0/1", i, out_valid, in_ready, busy);
      end
    end
    enb = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    n_cmp += 2;
    if (dt !== 8'd1) begin n_fail++; $display("FAIL freeze_dt got %0d want 1", dt); end
    if (lat != 15)   begin n_fail++; $display("FAIL freeze_latency got %0d want 15", lat); end
    ack8();
  endtask

  task automatic test_async_reset();
    logic [7:0] r; logic cp; int lat;
    @(negedge clk);
    dtx = 8'd128; dty = 8'd64; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || dt !== 8'd1) begin
      n_fail++; $display("FAIL areset_pre got busy=%b dt=%0d want 1/1", busy, dt);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || dt !== 8'd0 || coprime !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_outputs got ready=%b valid=%b busy=%b dt=%0d cp=%b want 1/0/0/0/0",
               in_ready, out_valid, busy, dt, coprime);
    end
    @(negedge clk);
    rst = 1'b0;
    run8(8'd9, 8'd6, r, cp, lat);
    n_cmp += 2;
    if (r !== 8'd3) begin n_fail++; $display("FAIL areset_next_dt got %0d want 3", r); end
    if (lat != 5)   begin n_fail++; $display("FAIL areset_next_latency got %0d want 5", lat); end
    ack8();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_backpressure();
    test_width16();
    test_enable_freeze();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
